// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: access size codes, the sign-extend
// bit position, FSM state encodings and small decode helpers.
package data_mem_pkg;

  // Size codes carried in sign_mask[2:0]
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  // sign_mask bit selecting sign extension of byte/half loads
  localparam int SIGN_BIT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    FINISH  = 2'd2
  } state_e;

  // True when the size code is known and the address is naturally aligned
  function automatic logic access_legal(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Byte lanes of a 32-bit word touched by an access of the given size
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word RAM: one-cycle read latency, write-first.
module dmem_sram
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Registered read or write of one word; a write also returns the new data
  // NOTE: no reset here on purpose -- a reset port would stop the array
  // mapping onto block RAM, and RAM contents are undefined after power-up.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/data_mem_rmw.sv
// Data memory for the load/store stage: sub-word loads/stores via
// read-modify-write over a single-port RAM, a bank of GPIO output registers,
// a stall to the core for RAM accesses and a fault pulse for illegal accesses.
module data_mem_rmw
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_2000,
  parameter int          NUM_GPIO    = 1,
  parameter int          GPIO_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    addr,
  input  logic [31:0]                    write_data,
  input  logic                           memwrite,
  input  logic                           memread,
  input  logic [3:0]                     sign_mask,
  output logic [31:0]                    read_data,
  output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_out,
  output logic                           clk_stall,
  output logic                           access_fault
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];
  localparam logic [29:0] RAM_WORDS = 30'(DEPTH_WORDS);

  state_e                         state_q, state_d;
  logic [AW-1:0]                  word_q, word_d;
  logic [1:0]                     lo_q, lo_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [3:0]                     mask_q, mask_d;
  logic                           is_write_q, is_write_d;
  logic [31:0]                    read_data_q, read_data_d;
  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_q, gpio_d;
  logic                           fault_q, fault_d;
  logic                           stall_c;

  logic        ram_en, ram_we;
  logic [31:0] ram_wdata, ram_rdata;

  // Request decode against the live inputs (only meaningful in IDLE)
  logic        req, legal, ram_hit, mmio_hit;
  logic [29:0] mmio_off;
  assign req      = memwrite | memread;
  assign legal    = access_legal(sign_mask[2:0], addr[1:0]);
  assign ram_hit  = (addr[31:2] < RAM_WORDS);
  assign mmio_off = addr[31:2] - MMIO_WORD;
  assign mmio_hit = (mmio_off < 30'(NUM_GPIO));

  // Zero-extended value of the addressed GPIO register
  logic [31:0] gpio_rd;
  always_comb begin
    gpio_rd = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (mmio_off == 30'(i)) gpio_rd[GPIO_WIDTH-1:0] = gpio_q[i*GPIO_WIDTH +: GPIO_WIDTH];
    end
  end

  // Lane merge for sub-word stores and lane extract/extend for loads
  logic [4:0]  shamt;
  logic [3:0]  lanes;
  logic [31:0] lane_bits, merged, shifted, load_ext;
  always_comb begin
    shamt   = {lo_q, 3'b000};
    lanes   = lane_mask(mask_q[2:0], lo_q);
    for (int k = 0; k < 4; k++) lane_bits[8*k +: 8] = {8{lanes[k]}};
    merged  = (ram_rdata & ~lane_bits) | ((wdata_q << shamt) & lane_bits);
    shifted = ram_rdata >> shamt;
    case (mask_q[2:0])
      SZ_BYTE: load_ext = {{24{mask_q[SIGN_BIT] & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{mask_q[SIGN_BIT] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state, datapath capture and RAM control
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    gpio_d      = gpio_q;
    fault_d     = 1'b0;
    stall_c     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_wdata   = merged;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!legal) begin
            fault_d = 1'b1;
          end else if (mmio_hit) begin
            if (memwrite) begin
              for (int i = 0; i < NUM_GPIO; i++) begin
                if (mmio_off == 30'(i)) gpio_d[i*GPIO_WIDTH +: GPIO_WIDTH] = write_data[GPIO_WIDTH-1:0];
              end
            end else begin
              read_data_d = gpio_rd;
            end
          end else if (ram_hit) begin
            stall_c    = 1'b1;
            word_d     = addr[AW+1:2];
            lo_d       = addr[1:0];
            wdata_d    = write_data;
            mask_d     = sign_mask;
            is_write_d = memwrite;
            // A full-word store needs no old data, so it skips the read
            state_d    = (memwrite && sign_mask[2:0] == SZ_WORD) ? FINISH : RD_WAIT;
          end else if (!memwrite) begin
            read_data_d = '0;
          end
        end
      end
      RD_WAIT: begin
        stall_c = 1'b1;
        ram_en  = 1'b1;
        state_d = FINISH;
      end
      FINISH: begin
        stall_c = 1'b1;
        state_d = IDLE;
        if (is_write_q) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = (mask_q[2:0] == SZ_WORD) ? wdata_q : merged;
        end else begin
          read_data_d = load_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      lo_q        <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
      gpio_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      gpio_q      <= gpio_d;
      fault_q     <= fault_d;
    end
  end

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (word_q),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign read_data    = read_data_q;
  assign gpio_out     = gpio_q;
  assign access_fault = fault_q;
  // The accepting-cycle stall is combinational, so gate it while in reset
  assign clk_stall    = stall_c & rst_n;

endmodule

// File: tb/tb_data_mem_rmw.sv
// Self-checking bench for data_mem_rmw: directed scenarios followed by
// randomized accesses compared against a byte-level reference model.
module tb_data_mem_rmw;
  import data_mem_pkg::*;

  localparam int NG = 2;
  localparam int GW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr, write_data;
  logic              memwrite, memread;
  logic [3:0]        sign_mask;
  logic [31:0]       read_data;
  logic [NG*GW-1:0]  gpio_out;
  logic              clk_stall, access_fault;

  always #5 clk = ~clk;

  data_mem_rmw #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (32'h0000_2000),
    .NUM_GPIO   (NG),
    .GPIO_WIDTH (GW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .write_data  (write_data),
    .memwrite    (memwrite),
    .memread     (memread),
    .sign_mask   (sign_mask),
    .read_data   (read_data),
    .gpio_out    (gpio_out),
    .clk_stall   (clk_stall),
    .access_fault(access_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: RAM as little-endian bytes (first 64 bytes), GPIO regs, load result
  logic [7:0]  m_mem  [64];
  logic [7:0]  m_gpio [NG];
  logic [31:0] m_rd;

  function automatic int nbytes(input logic [2:0] sz);
    if (sz == SZ_BYTE) return 1;
    if (sz == SZ_HALF) return 2;
    return 4;
  endfunction

  function automatic logic m_legal(input logic [2:0] sz, input logic [31:0] a);
    if (sz != SZ_BYTE && sz != SZ_HALF && sz != SZ_WORD) return 1'b0;
    return (a % nbytes(sz)) == 0;
  endfunction

  // One access: update the model, drive the request, count stall cycles and
  // compare stall length, fault, load result and GPIO state.
  task automatic run_op(input string tag, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sm, output int stalls);
    logic [2:0]  sz;
    int          nb, exp_stall, guard, idx;
    logic        exp_fault, flt, st;
    logic [31:0] v;
    sz        = sm[2:0];
    nb        = nbytes(sz);
    exp_stall = 0;
    exp_fault = !m_legal(sz, a);
    if (!exp_fault) begin
      if (a >= 32'h2000 && a < 32'h2000 + 4*NG) begin
        idx = int'((a - 32'h2000) / 4);
        if (wr) m_gpio[idx] = wd[7:0];
        else    m_rd = {24'h0, m_gpio[idx]};
      end else if (a < 32'd4096) begin
        exp_stall = (wr && nb == 4) ? 2 : 3;
        if (wr) begin
          for (int k = 0; k < nb; k++) m_mem[int'(a) + k] = wd[8*k +: 8];
        end else begin
          v = '0;
          for (int k = 0; k < nb; k++) v[8*k +: 8] = m_mem[int'(a) + k];
          if (sm[3] && nb < 4 && v[8*nb-1]) v = v | (32'hffff_ffff << (8*nb));
          m_rd = v;
        end
      end else if (!wr) begin
        m_rd = '0;
      end
    end

    addr = a; write_data = wd; memwrite = wr; memread = rd; sign_mask = sm;
    @(negedge clk);
    stalls = clk_stall ? 1 : 0;
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
    @(negedge clk);
    flt   = access_fault;
    st    = clk_stall;
    guard = 0;
    while (st && guard < 10) begin
      stalls++;
      guard++;
      @(posedge clk); #1;
      @(negedge clk);
      st = clk_stall;
    end
    check({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_fault});
    check({tag, "_rdata"}, read_data, m_rd);
    check({tag, "_gpio"}, 32'(gpio_out), {16'h0, m_gpio[1], m_gpio[0]});
    @(posedge clk); #1;
    check({tag, "_fault_clr"}, {31'b0, access_fault}, 32'h0);
  endtask

  int          st;
  logic [2:0]  bad_codes [5];
  logic [2:0]  sz;
  logic [31:0] a, wd, pre;
  logic        wr, rd;
  int          kind, pick, nb;

  initial begin
    bad_codes[0] = 3'b000; bad_codes[1] = 3'b010; bad_codes[2] = 3'b100;
    bad_codes[3] = 3'b101; bad_codes[4] = 3'b110;
    m_rd = '0;
    for (int i = 0; i < NG; i++) m_gpio[i] = '0;
    rst_n = 1'b0; addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    #12;
    check("rst_rdata", read_data, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_stall", {31'b0, clk_stall}, 32'h0);
    check("rst_fault", {31'b0, access_fault}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Give the modelled RAM region known contents
    for (int w = 0; w < 16; w++) run_op("init", 1'b1, 1'b0, 32'(4*w), $urandom, 4'b0111, st);

    // 1: word store then word load
    run_op("t1_sw", 1'b1, 1'b0, 32'h4, 32'hff03ab21, 4'b0111, st);
    check("t1_sw_len", 32'(st), 32'd2);
    run_op("t1_lw", 1'b0, 1'b1, 32'h4, 32'h0, 4'b0111, st);
    check("t1_lw_len", 32'(st), 32'd3);
    check("t1_lw_val", read_data, 32'hff03ab21);

    // 2: half store merged into a word
    run_op("t2_sw", 1'b1, 1'b0, 32'h8, 32'h12345678, 4'b0111, st);
    run_op("t2_sh", 1'b1, 1'b0, 32'hA, 32'h0000ab21, 4'b0011, st);
    check("t2_sh_len", 32'(st), 32'd3);
    run_op("t2_lw", 1'b0, 1'b1, 32'h8, 32'h0, 4'b0111, st);
    check("t2_lw_val", read_data, 32'hab215678);
    run_op("t2_lh", 1'b0, 1'b1, 32'hA, 32'h0, 4'b1011, st);
    check("t2_lh_val", read_data, 32'hffffab21);
    run_op("t2_lhu", 1'b0, 1'b1, 32'hA, 32'h0, 4'b0011, st);
    check("t2_lhu_val", read_data, 32'h0000ab21);

    // 3: byte store into the top lane
    run_op("t3_sw", 1'b1, 1'b0, 32'h10, 32'h0, 4'b0111, st);
    run_op("t3_sb", 1'b1, 1'b0, 32'h13, 32'h83, 4'b0001, st);
    run_op("t3_lbu", 1'b0, 1'b1, 32'h13, 32'h0, 4'b0001, st);
    check("t3_lbu_val", read_data, 32'h00000083);
    run_op("t3_lb", 1'b0, 1'b1, 32'h13, 32'h0, 4'b1001, st);
    check("t3_lb_val", read_data, 32'hffffff83);
    run_op("t3_lw", 1'b0, 1'b1, 32'h10, 32'h0, 4'b0111, st);
    check("t3_lw_val", read_data, 32'h83000000);

    // 4: misaligned and illegal-size accesses
    pre = read_data;
    run_op("t4_lw_mis", 1'b0, 1'b1, 32'h6, 32'h0, 4'b0111, st);
    check("t4_lw_keep", read_data, 32'h83000000);
    run_op("t4_lh_mis", 1'b0, 1'b1, 32'h5, 32'h0, 4'b0011, st);
    run_op("t4_badsz", 1'b0, 1'b1, 32'h4, 32'h0, 4'b0010, st);
    check("t4_badsz_keep", read_data, pre);

    // 5: GPIO bank and unmapped store
    run_op("t5_g0", 1'b1, 1'b0, 32'h2000, 32'ha5, 4'b0111, st);
    run_op("t5_g1", 1'b1, 1'b0, 32'h2004, 32'h3c, 4'b0111, st);
    check("t5_gpio_val", 32'(gpio_out), 32'h3ca5);
    run_op("t5_lg0", 1'b0, 1'b1, 32'h2000, 32'h0, 4'b1111, st);
    check("t5_lg0_val", read_data, 32'h000000a5);
    run_op("t5_unmap", 1'b1, 1'b0, 32'h3000, 32'hff, 4'b0111, st);
    check("t5_unmap_gpio", 32'(gpio_out), 32'h3ca5);

    // 6: reset during RD_WAIT abandons a half store
    addr = 32'h8; write_data = 32'hbeef; memwrite = 1'b1; memread = 1'b0; sign_mask = 4'b0011;
    @(negedge clk);
    @(posedge clk); #1;
    memwrite = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rdata", read_data, 32'h0);
    check("t6_rst_gpio", 32'(gpio_out), 32'h0);
    check("t6_rst_stall", {31'b0, clk_stall}, 32'h0);
    check("t6_rst_fault", {31'b0, access_fault}, 32'h0);
    m_rd = '0;
    for (int i = 0; i < NG; i++) m_gpio[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("t6_lw", 1'b0, 1'b1, 32'h8, 32'h0, 4'b0111, st);
    check("t6_lw_val", read_data, 32'hab215678);

    // Randomized mix of RAM, GPIO, unmapped and illegal accesses
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 7);
      if (pick <= 2)      sz = SZ_BYTE;
      else if (pick <= 4) sz = SZ_HALF;
      else if (pick <= 6) sz = SZ_WORD;
      else                sz = bad_codes[$urandom_range(0, 4)];
      nb   = nbytes(sz);
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'h2000 + 32'($urandom_range(0, 11));
      else if (kind == 1) a = 32'h3000 + 32'($urandom_range(0, 255));
      else                a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) a = a & ~(32'(nb) - 32'd1);
      pick = $urandom_range(0, 2);
      wr   = (pick != 0);
      rd   = (pick != 1);
      wd   = $urandom;
      run_op("rnd", wr, rd, a, wd, {1'($urandom_range(0, 1)), sz}, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
